// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one external combinational ALU between two requesters.
// One operation in flight: operands are held on the ALU for EXEC_CYCLES cycles, then the result is returned.
module alu_rr_sequencer #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_id,
    output logic             rsp_err
);

    // state | meaning
    // IDLE  | waiting for a request; readys driven combinationally from the grant
    // EXEC  | operands held on the ALU, down-counter running to terminal count
    // RESP  | result presented on rsp_*, waiting for rsp_ready

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [3:0] SEL_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]         alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant;
    logic               accept;
    logic               exec_done;
    logic               div_zero;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else if (req1_valid)          grant = 1'b1;
    end

    assign accept    = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign exec_done = (state_q == S_EXEC) && (cnt_q == '0);
    assign div_zero  = (alu_sel_q == SEL_DIV) && (alu_b_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = accept ? S_EXEC : S_IDLE;
            S_EXEC:  state_d = exec_done ? S_RESP : S_EXEC;
            S_RESP:  state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        if (accept) begin
            alu_a_d      = grant ? req1_a   : req0_a;
            alu_b_d      = grant ? req1_b   : req0_b;
            alu_sel_d    = grant ? req1_sel : req0_sel;
            rsp_id_d     = grant;
            last_grant_d = grant;
            cnt_d        = CNT_LOAD;
        end else if (exec_done) begin
            rsp_data_d  = div_zero ? '1 : alu_out;
            rsp_carry_d = alu_carry;
            rsp_err_d   = div_zero;
        end else if (state_q == S_EXEC) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=4,
// each driven by a small behavioural ALU model.
module tb_alu_rr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference ALU: carry is always the carry of A+B; div by zero returns a marker the DUT must override.
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel);
        logic [16:0] sum;
        logic [15:0] res;
        sum = {1'b0, a} + {1'b0, b};
        case (sel)
            4'd0:    res = sum[15:0];
            4'd1:    res = a - b;
            4'd2:    res = a * b;
            4'd3:    res = (b == 16'd0) ? 16'hDEAD : a / b;
            4'd4:    res = a & b;
            default: res = a | b;
        endcase
        return {sum[16], res};
    endfunction

    // Instance with EXEC_CYCLES = 1
    logic        rst_n, req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]  req0_sel, req1_sel, alu_sel;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_id, rsp_err;

    assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    alu_rr_sequencer #(.WIDTH(16), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // Instance with EXEC_CYCLES = 4
    logic        x_rst_n, x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
    logic [15:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b, x_alu_a, x_alu_b, x_alu_out, x_rsp_data;
    logic [3:0]  x_req0_sel, x_req1_sel, x_alu_sel;
    logic        x_alu_carry, x_rsp_valid, x_rsp_ready, x_rsp_carry, x_rsp_id, x_rsp_err;

    assign {x_alu_carry, x_alu_out} = alu_f(x_alu_a, x_alu_b, x_alu_sel);

    alu_rr_sequencer #(.WIDTH(16), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(x_rst_n),
        .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_sel(x_req0_sel),
        .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_a(x_req1_a), .req1_b(x_req1_b), .req1_sel(x_req1_sel),
        .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_sel(x_alu_sel), .alu_out(x_alu_out), .alu_carry(x_alu_carry),
        .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data), .rsp_carry(x_rsp_carry),
        .rsp_id(x_rsp_id), .rsp_err(x_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op on the EXEC_CYCLES=1 instance with rsp_ready held high; called 1 time unit after an edge.
    task automatic do_op(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sel, input logic [15:0] ed, input logic ec, input logic ee);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        #1;
        chk({tag, ".ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".data"},  32'(rsp_data),  32'(ed));
        chk({tag, ".carry"}, 32'(rsp_carry), 32'(ec));
        chk({tag, ".id"},    32'(rsp_id),    32'(id));
        chk({tag, ".err"},   32'(rsp_err),   32'(ee));
        step();
        chk({tag, ".done"},  32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; x_rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0; rsp_ready = 1'b1;
        x_req0_valid = 0; x_req1_valid = 0; x_req0_a = 0; x_req0_b = 0; x_req0_sel = 0;
        x_req1_a = 0; x_req1_b = 0; x_req1_sel = 0; x_rsp_ready = 1'b1;
        #1;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.alu_a", 32'(alu_a), 32'd0);
        chk("rst.data",  32'(rsp_data), 32'd0);
        chk("rst.id",    32'(rsp_id), 32'd0);
        step();
        rst_n = 1'b1; x_rst_n = 1'b1;
        step();

        do_op("add", 1'b0, 16'd3, 16'd4, 4'd0, 16'd7, 1'b0, 1'b0);

        // Fresh reset, then both requesters continuously valid: grants must alternate starting with req0.
        rst_n = 1'b0;
        #1;
        chk("rst2.valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        req0_a = 16'd10; req0_b = 16'd1; req0_sel = 4'd0;
        req1_a = 16'd20; req1_b = 16'd2; req1_sel = 4'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr%0d.r0", i), 32'(req0_ready), 32'(i % 2 == 0));
            chk($sformatf("rr%0d.r1", i), 32'(req1_ready), 32'(i % 2 == 1));
            step();
            chk($sformatf("rr%0d.exec", i), 32'(rsp_valid), 32'd0);
            step();
            chk($sformatf("rr%0d.id", i),   32'(rsp_id),   32'(i % 2));
            chk($sformatf("rr%0d.data", i), 32'(rsp_data), (i % 2 == 0) ? 32'd11 : 32'd18);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        do_op("ovf",  1'b0, 16'hFFFF, 16'd1, 4'd0, 16'h0000, 1'b1, 1'b0);
        do_op("div0", 1'b0, 16'd9,    16'd0, 4'd3, 16'hFFFF, 1'b0, 1'b1);
        do_op("div",  1'b1, 16'd100,  16'd7, 4'd3, 16'd14,   1'b0, 1'b0);

        // Back-pressure: response held for 5 cycles with both requesters waiting.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd6; req1_sel = 4'd4;
        #1;
        chk("bp.accept", 32'(req1_ready), 32'd1);
        step();
        req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1; req0_sel = 4'd0;
        chk("bp.exec_r0", 32'(req0_ready), 32'd0);
        chk("bp.exec_r1", 32'(req1_ready), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d.valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d.data", k),  32'(rsp_data),  32'd4);
            chk($sformatf("bp%0d.id", k),    32'(rsp_id),    32'd1);
            chk($sformatf("bp%0d.r0", k),    32'(req0_ready), 32'd0);
            chk($sformatf("bp%0d.r1", k),    32'(req1_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.hs_valid", 32'(rsp_valid), 32'd1);
        chk("bp.hs_r0",    32'(req0_ready), 32'd0);
        chk("bp.hs_r1",    32'(req1_ready), 32'd0);
        step();
        chk("bp.idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp.idle_r0",    32'(req0_ready), 32'd1);
        chk("bp.idle_r1",    32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // EXEC_CYCLES = 4: operands stable for 4 cycles, capture on the 4th edge.
        x_req0_valid = 1'b1; x_req0_a = 16'd7; x_req0_b = 16'd6; x_req0_sel = 4'd2;
        #1;
        chk("mc.accept", 32'(x_req0_ready), 32'd1);
        step();
        x_req0_valid = 1'b0; x_req0_a = 16'h1234; x_req0_b = 16'h5678; x_req0_sel = 4'd5;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mc%0d.a", k),     32'(x_alu_a),   32'd7);
            chk($sformatf("mc%0d.b", k),     32'(x_alu_b),   32'd6);
            chk($sformatf("mc%0d.sel", k),   32'(x_alu_sel), 32'd2);
            chk($sformatf("mc%0d.valid", k), 32'(x_rsp_valid), 32'd0);
            step();
        end
        chk("mc.valid", 32'(x_rsp_valid), 32'd1);
        chk("mc.data",  32'(x_rsp_data),  32'd42);
        chk("mc.id",    32'(x_rsp_id),    32'd0);
        step();
        chk("mc.done", 32'(x_rsp_valid), 32'd0);

        // Reset in EXEC: op dropped, outputs cleared, req0 wins the next tie.
        x_req0_valid = 1'b1; x_req0_a = 16'd2; x_req0_b = 16'd3; x_req0_sel = 4'd0;
        #1;
        step();
        x_req0_valid = 1'b0;
        step();
        x_rst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(x_rsp_valid), 32'd0);
        chk("mrst.alu_a", 32'(x_alu_a),     32'd0);
        chk("mrst.data",  32'(x_rsp_data),  32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mrst%0d.valid", k), 32'(x_rsp_valid), 32'd0);
        end
        x_rst_n = 1'b1;
        x_req0_valid = 1'b1; x_req1_valid = 1'b1;
        #1;
        chk("mrst.r0", 32'(x_req0_ready), 32'd1);
        chk("mrst.r1", 32'(x_req1_ready), 32'd0);
        x_req0_valid = 1'b0; x_req1_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("mrst_idle%0d.valid", k), 32'(x_rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
